// File: rtl/parity_frame_checker_if.sv
// Bundles the serial receive stream, mode/clear controls and per-frame status of
// the parity frame checker into one interface.
interface parity_frame_checker_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
);
    logic                 data_in;
    logic                 valid;
    logic [1:0]           mode;
    logic                 clr_err;
    logic                 busy;
    logic                 frame_done;
    logic                 parity_ok;
    logic                 parity_err;
    logic                 frame_abort;
    logic [DATA_BITS-1:0] data_out;
    logic [CNT_W-1:0]     err_count;

    modport master (
        output data_in, valid, mode, clr_err,
        input  busy, frame_done, parity_ok, parity_err, frame_abort, data_out, err_count
    );

    modport slave (
        input  data_in, valid, mode, clr_err,
        output busy, frame_done, parity_ok, parity_err, frame_abort, data_out, err_count
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial parity-frame checker: assembles DATA_BITS data bits plus one parity bit,
// checks parity under a per-frame latched scheme, counts errors and aborts stalled frames.
//
// state | meaning
// IDLE  | waiting for data bit 0 of a frame
// RECV  | collecting data bits 1..DATA_BITS-1
// PAR   | waiting for the parity bit
module parity_frame_checker #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8,
    parameter int GAP_MAX   = 4
) (
    input logic                    clk,
    input logic                    reset,
    parity_frame_checker_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 xor_q, xor_d;
    logic [1:0]           mode_q, mode_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 parity_ok_q, parity_ok_d;
    logic                 frame_done_q, frame_done_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_abort_q, frame_abort_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;
    logic                 exp_par;

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        gap_d         = gap_q;
        xor_d         = xor_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        parity_ok_d   = parity_ok_q;
        frame_done_d  = 1'b0;
        parity_err_d  = 1'b0;
        frame_abort_d = 1'b0;
        err_count_d   = err_count_q;

        case (mode_q)
            2'b00:   exp_par = xor_q;
            2'b01:   exp_par = ~xor_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    shift_d    = '0;
                    shift_d[0] = bus.data_in;
                    xor_d      = bus.data_in;
                    mode_d     = bus.mode;
                    bit_idx_d  = IDX_W'(1);
                    gap_d      = '0;
                    state_d    = (DATA_BITS == 1) ? PAR : RECV;
                end
            end
            RECV, PAR: begin
                if (bus.valid) begin
                    gap_d = '0;
                    if (state_q == RECV) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_idx_q == IDX_W'(i)) shift_d[i] = bus.data_in;
                        end
                        xor_d     = xor_q ^ bus.data_in;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_d = PAR;
                    end else begin
                        frame_done_d = 1'b1;
                        parity_ok_d  = (bus.data_in == exp_par);
                        parity_err_d = (bus.data_in != exp_par);
                        data_out_d   = shift_q;
                        state_d      = IDLE;
                    end
                end else if (gap_q == GAP_W'(GAP_MAX)) begin
                    frame_abort_d = 1'b1;
                    gap_d         = '0;
                    state_d       = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear coinciding with a detected error keeps that error counted.
        if (bus.clr_err) begin
            err_count_d = CNT_W'(parity_err_d);
        end else if (parity_err_d && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            gap_q         <= '0;
            xor_q         <= 1'b0;
            mode_q        <= 2'b00;
            shift_q       <= '0;
            data_out_q    <= '0;
            parity_ok_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            gap_q         <= gap_d;
            xor_q         <= xor_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            parity_ok_q   <= parity_ok_d;
            frame_done_q  <= frame_done_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.parity_ok   = parity_ok_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.data_out    = data_out_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_BITS=8, CNT_W=2, GAP_MAX=4).
module tb_parity_frame_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    parity_frame_checker_if #(.DATA_BITS(8), .CNT_W(2)) pif ();

    parity_frame_checker #(.DATA_BITS(8), .CNT_W(2), .GAP_MAX(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        pif.valid   = 1'b1;
        pif.data_in = b;
        tick();
        pif.valid   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] m,
                              input logic clr_at_par);
        pif.mode = m;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        pif.clr_err = clr_at_par;
        send_bit(p);
        pif.clr_err = 1'b0;
    endtask

    initial begin
        int first_done;
        int second_done;
        int n_done;
        logic [17:0] b2b;

        pif.data_in = 1'b0;
        pif.valid   = 1'b0;
        pif.mode    = 2'b00;
        pif.clr_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_busy", pif.busy, 0);
        check_eq("rst_data", pif.data_out, 0);
        check_eq("rst_ok", pif.parity_ok, 0);
        check_eq("rst_cnt", pif.err_count, 0);
        check_eq("rst_done", pif.frame_done, 0);

        // even 0xA5, four ones -> parity 0 good
        send_frame(8'hA5, 1'b0, 2'b00, 1'b0);
        check_eq("t1_done", pif.frame_done, 1);
        check_eq("t1_data", pif.data_out, 32'hA5);
        check_eq("t1_ok", pif.parity_ok, 1);
        check_eq("t1_err", pif.parity_err, 0);
        check_eq("t1_cnt", pif.err_count, 0);
        tick();
        check_eq("t1_pulse", pif.frame_done, 0);
        check_eq("t1_hold", pif.data_out, 32'hA5);

        // odd: 0xA5 needs parity 1, so 0 is an error; 0x01 needs 0
        send_frame(8'hA5, 1'b0, 2'b01, 1'b0);
        check_eq("t2_err", pif.parity_err, 1);
        check_eq("t2_ok", pif.parity_ok, 0);
        check_eq("t2_cnt", pif.err_count, 1);
        send_frame(8'h01, 1'b0, 2'b01, 1'b0);
        check_eq("t2b_ok", pif.parity_ok, 1);
        check_eq("t2b_err", pif.parity_err, 0);
        check_eq("t2b_cnt", pif.err_count, 1);

        // 4-cycle gap tolerated
        pif.mode = 2'b00;
        for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i));
        for (int i = 0; i < 4; i++) tick();
        check_eq("t3_busy_gap", pif.busy, 1);
        check_eq("t3_no_abort", pif.frame_abort, 0);
        for (int i = 4; i < 8; i++) send_bit(1'(8'h3C >> i));
        send_bit(1'b0);
        check_eq("t3_done", pif.frame_done, 1);
        check_eq("t3_data", pif.data_out, 32'h3C);
        check_eq("t3_ok", pif.parity_ok, 1);
        // 5-cycle gap aborts
        for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i));
        for (int i = 0; i < 4; i++) tick();
        check_eq("t3_abort_early", pif.frame_abort, 0);
        tick();
        check_eq("t3_abort", pif.frame_abort, 1);
        check_eq("t3_abort_done", pif.frame_done, 0);
        check_eq("t3_abort_busy", pif.busy, 0);
        check_eq("t3_abort_data", pif.data_out, 32'h3C);
        check_eq("t3_abort_cnt", pif.err_count, 1);
        tick();
        check_eq("t3_abort_pulse", pif.frame_abort, 0);
        send_frame(8'h5A, 1'b0, 2'b00, 1'b0);
        check_eq("t3_fresh_done", pif.frame_done, 1);
        check_eq("t3_fresh_data", pif.data_out, 32'h5A);
        check_eq("t3_fresh_ok", pif.parity_ok, 1);

        // mark frame, mode flipped to space after bit 2: must still fail
        pif.mode = 2'b10;
        for (int i = 0; i < 3; i++) send_bit(1'(8'h0F >> i));
        pif.mode = 2'b11;
        for (int i = 3; i < 8; i++) send_bit(1'(8'h0F >> i));
        send_bit(1'b0);
        check_eq("t4_mark_err", pif.parity_err, 1);
        check_eq("t4_mark_ok", pif.parity_ok, 0);
        check_eq("t4_cnt", pif.err_count, 2);
        send_frame(8'hFF, 1'b0, 2'b11, 1'b0);
        check_eq("t4_space_ok", pif.parity_ok, 1);
        send_frame(8'h00, 1'b1, 2'b10, 1'b0);
        check_eq("t4_mark_good", pif.parity_ok, 1);
        check_eq("t4_cnt_hold", pif.err_count, 2);

        // saturation at 3 with CNT_W=2
        pif.clr_err = 1'b1;
        tick();
        pif.clr_err = 1'b0;
        check_eq("t5_clr", pif.err_count, 0);
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h00, 1'b1, 2'b00, 1'b0);
            check_eq("t5_sat", pif.err_count, (k < 3) ? k + 1 : 3);
        end
        send_frame(8'h00, 1'b1, 2'b00, 1'b1);
        check_eq("t5_clr_err", pif.err_count, 1);
        check_eq("t5_clr_pulse", pif.parity_err, 1);

        // back-to-back: 0x81+p0 then 0x7E+p0 with valid held high
        b2b = {1'b0, 8'h7E, 1'b0, 8'h81};
        first_done = -1;
        second_done = -1;
        n_done = 0;
        pif.mode = 2'b00;
        for (int j = 0; j < 18; j++) begin
            send_bit(b2b[j]);
            if (pif.frame_done) begin
                n_done++;
                if (first_done < 0) first_done = j;
                else second_done = j;
            end
        end
        check_eq("t6_ndone", n_done, 2);
        check_eq("t6_first", first_done, 8);
        check_eq("t6_spacing", second_done - first_done, 9);
        check_eq("t6_data", pif.data_out, 32'h7E);
        check_eq("t6_ok", pif.parity_ok, 1);

        // reset mid-frame
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_busy", pif.busy, 0);
        check_eq("t6_rst_data", pif.data_out, 0);
        check_eq("t6_rst_cnt", pif.err_count, 0);
        check_eq("t6_rst_ok", pif.parity_ok, 0);
        check_eq("t6_rst_pulses", {pif.frame_done, pif.parity_err, pif.frame_abort}, 0);
        send_frame(8'hC3, 1'b0, 2'b00, 1'b0);
        check_eq("t6_after_done", pif.frame_done, 1);
        check_eq("t6_after_data", pif.data_out, 32'hC3);
        check_eq("t6_after_ok", pif.parity_ok, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Parametrised serial parity-frame checker and the successor to the single-bit even/odd parity checker. It accepts a serial stream qualified by valid, assembles a frame of DATA_BITS data bits followed by one parity bit, and checks the parity bit against a run-time-selected scheme (even, odd, mark or space). Per frame it reports a registered result with the captured data word. It also keeps a saturating parity-error counter and aborts frames that stall too long. It sits behind the serial receive front-end and feeds frame status into the link-monitor logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 1..32, LSB received first
CNT_W, 8, width of the saturating error counter
GAP_MAX, 4, consecutive valid-low cycles tolerated inside a frame; 0 aborts on any gap

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial bit, sampled only when valid=1
valid  input  1  qualifies data_in
mode  input  2  parity scheme: 00 even, 01 odd, 10 mark (parity bit must be 1), 11 space (parity bit must be 0)
clr_err  input  1  synchronous clear of err_count
busy  output  1  high while a frame is in progress (RECV or PAR state)
frame_done  output  1  one-cycle pulse when a frame completes
parity_ok  output  1  result of the last completed frame; held until the next frame_done
parity_err  output  1  one-cycle pulse, coincident with frame_done, when the parity check fails
frame_abort  output  1  one-cycle pulse when a frame is dropped on a gap timeout
data_out  output  DATA_BITS  data word of the last completed frame; held until the next frame_done
err_count  output  CNT_W  saturating count of parity errors

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. Bit index, gap counter, running XOR and latched mode clear. All outputs go to 0. Reset mid-frame discards the frame with no pulses.
- States are IDLE, RECV and PAR.
- IDLE: a cycle with valid=1 accepts data bit 0. In that cycle:
  - data_in goes into shift position 0;
  - running XOR is set to data_in;
  - mode is latched;
  - next state is RECV, or PAR if DATA_BITS=1.
- RECV: each valid=1 cycle stores data_in at the current bit index and XORs it into the running parity. When the last data bit (index DATA_BITS-1) is accepted, next state is PAR.
- PAR: a valid=1 cycle takes data_in as the parity bit, and next state is IDLE.
- Expected parity bit, using the latched mode:
  - even: XOR of the data bits;
  - odd: inverse of the XOR;
  - mark: 1;
  - space: 0.
- Mode changes mid-frame are ignored. The new mode applies from the next frame's first bit.
- Latency: frame_done pulses in the cycle after the edge that samples the parity bit. On that same cycle:
  - data_out and parity_ok update;
  - parity_err = ~parity_ok.
- Back-to-back frames: a valid bit in the cycle immediately after the parity bit is data bit 0 of the next frame. No idle cycle is required.
- Gap handling (RECV and PAR only):
  - each valid=0 cycle increments the gap counter, and any valid=1 cycle clears it;
  - if valid=0 while the gap counter already equals GAP_MAX, the frame aborts;
  - on abort: frame_abort pulses next cycle, state goes to IDLE, and the partial data is discarded;
  - on abort, data_out, parity_ok and err_count are unchanged, and frame_done does not pulse;
  - so GAP_MAX+1 consecutive low cycles abort a frame, and GAP_MAX or fewer do not;
  - in IDLE, valid=0 is ignored.
- err_count:
  - increments by 1 on each parity_err;
  - saturates at 2^CNT_W-1 with no wrap;
  - clr_err sets it to 0;
  - clr_err in the same cycle as a parity error sets it to 1 (the error is not lost).
- Width rules:
  - bit index width is clog2(DATA_BITS+1);
  - gap counter width is clog2(GAP_MAX+1), with a minimum of 1.
- frame_done, parity_err and frame_abort are never asserted in the same cycle as each other's opposing event; frame_done and frame_abort are mutually exclusive.
- busy is 1 in RECV and PAR, and 0 in IDLE.

Test Plan:
1. Even mode, DATA_BITS=8: stream 0xA5 LSB-first then parity bit 0 -> frame_done one cycle after the parity edge, data_out=0xA5, parity_ok=1, parity_err=0, err_count=0.
2. Odd mode: same 0xA5 frame with parity bit 0 -> parity_err pulse, parity_ok=0, err_count=1. Then stream 0x01 with parity bit 0 -> parity_ok=1, err_count stays 1.
3. GAP_MAX=4:
   - valid low for 4 cycles after bit 3 -> frame completes normally;
   - valid low for 5 cycles -> frame_abort pulse, busy=0, data_out and err_count unchanged;
   - the next 9 valid bits form a fresh, correct frame.
4. Mark and space modes, with mode toggled mid-frame: mark frame with parity bit 0 -> error. Switching mode to space after bit 2 has no effect on that frame's check.
5. CNT_W=2: five bad frames -> err_count=3 (saturated). clr_err coincident with a sixth error -> err_count=1.
6. Back-to-back frames with valid held high for 18 cycles -> two frame_done pulses exactly 9 cycles apart. Reset asserted mid-frame -> all outputs 0, no pulse, and the next frame decodes correctly.
